// File: rtl/board_io_pkg.sv
// Shared definitions for the board input conditioner.
// Optional feature macro: BOARD_IO_BOTH_EDGES_EN (falling edges also raise pending bits).
package board_io_pkg;

    // Default synchroniser depth and debounce window.
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;

    // Which debounced edges raise an interrupt-pending bit.
    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_BOTH = 1'b1
    } edge_mode_e;

`ifdef BOARD_IO_BOTH_EDGES_EN
    localparam edge_mode_e EDGE_MODE = EDGE_BOTH;
`else
    localparam edge_mode_e EDGE_MODE = EDGE_RISE;
`endif

    // Counter width able to hold the value 'cycles'.
    function automatic int cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/io_debounce_ch.sv
// Single-channel synchroniser plus debouncer with edge pulses.
// Optional feature macro: BOARD_IO_BOTH_EDGES_EN (enables fall_o).
module io_debounce_ch
    import board_io_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int             CNT_W   = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   prev_q;

    assign synced = sync_q[SYNC_STAGES-1];

    // Plain flop chain bringing the asynchronous pin into the clock domain.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
        end
    end

    // Count consecutive cycles the synced input differs from the accepted level.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (synced == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = synced;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Debounce state and previous level used for edge detection.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            prev_q   <= stable_q;
        end
    end

    assign level_o = stable_q;
    assign rise_o  = stable_q & ~prev_q;

`ifdef BOARD_IO_BOTH_EDGES_EN
    assign fall_o = ~stable_q & prev_q;
`else
    assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/board_io_cond.sv
// Board input conditioner: debounced buttons/switches, edge pulses and
// sticky maskable button interrupts.
// Optional feature macro: BOARD_IO_BOTH_EDGES_EN (falling edges pulse btn_fall_o and set pending).
module board_io_cond
    import board_io_pkg::*;
#(
    parameter int NUM_BTN         = 5,
    parameter int NUM_SW          = 16,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic [NUM_BTN-1:0] btn_i,
    input  logic [NUM_SW-1:0]  sw_i,
    input  logic [NUM_BTN-1:0] irq_mask_i,
    input  logic [NUM_BTN-1:0] irq_ack_i,
    output logic [NUM_BTN-1:0] btn_o,
    output logic [NUM_SW-1:0]  sw_o,
    output logic [NUM_BTN-1:0] btn_rise_o,
    output logic [NUM_BTN-1:0] btn_fall_o,
    output logic [NUM_BTN-1:0] irq_pending_o,
    output logic               irq_o
);

    logic [NUM_BTN-1:0] btn_rise_w;
    logic [NUM_BTN-1:0] btn_fall_w;
    logic [NUM_SW-1:0]  sw_rise_unused;
    logic [NUM_SW-1:0]  sw_fall_unused;
    logic [NUM_BTN-1:0] pend_q, pend_d;
    logic [NUM_BTN-1:0] pend_set;

    // One conditioning channel per button.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        io_debounce_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk_i   (clk_i),
            .arst_i  (arst_i),
            .pin_i   (btn_i[i]),
            .level_o (btn_o[i]),
            .rise_o  (btn_rise_w[i]),
            .fall_o  (btn_fall_w[i])
        );
    end

    // One conditioning channel per switch; switch edges are not used.
    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        io_debounce_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk_i   (clk_i),
            .arst_i  (arst_i),
            .pin_i   (sw_i[i]),
            .level_o (sw_o[i]),
            .rise_o  (sw_rise_unused[i]),
            .fall_o  (sw_fall_unused[i])
        );
    end

    assign btn_rise_o = btn_rise_w;
    assign btn_fall_o = btn_fall_w;

`ifdef BOARD_IO_BOTH_EDGES_EN
    assign pend_set = btn_rise_w | btn_fall_w;
`else
    assign pend_set = btn_rise_w;
`endif

    // Sticky pending: ack clears, a same-cycle edge wins over the ack.
    always_comb begin
        pend_d = (pend_q & ~irq_ack_i) | pend_set;
    end

    // Pending register, latched independently of the mask.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign irq_pending_o = pend_q;
    assign irq_o         = |(pend_q & irq_mask_i);

endmodule
